// File: rtl/stream_strlen.sv
// rtl/stream_strlen.sv - streaming C-string length counter over B-byte words
//
// Scans each accepted word for the first NUL byte (MSB byte first), accumulates
// the length across words and presents it on a registered valid/ready output.
// Optional macro: STRLEN_WORD_LIMIT_EN adds a per-string word limit (MAX_WORDS)
// that ends the string with len_timeout=1 when no NUL has been seen.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous, active-high reset
//   in_data      string word, byte [8*B-1:8*B-8] is the first character
//   in_valid     in_data is valid
//   in_ready     word accepted this cycle (depends on state only)
//   len          string length in bytes before the first NUL (saturating)
//   len_valid    len holds a result
//   len_ready    consumer takes the result
//   len_ovf      length saturated at 2^LEN_WIDTH-1
//   len_timeout  word limit hit before a NUL; constant 0 without the macro

module stream_strlen #(
   parameter int BYTES_PER_WORD = 8,
   parameter int LEN_WIDTH      = 16,
   parameter int MAX_WORDS      = 64
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [8*BYTES_PER_WORD-1:0] in_data,
   input  logic                        in_valid,
   output logic                        in_ready,
   output logic [LEN_WIDTH-1:0]        len,
   output logic                        len_valid,
   input  logic                        len_ready,
   output logic                        len_ovf,
   output logic                        len_timeout
);

   localparam int DW  = 8 * BYTES_PER_WORD;
   localparam int LW1 = LEN_WIDTH + 1;

   if (BYTES_PER_WORD < 1) begin : g_bytes_check
      $error("BYTES_PER_WORD must be at least 1");
   end
   if (MAX_WORDS < 1) begin : g_max_words_check
      $error("MAX_WORDS must be at least 1");
   end

   typedef enum logic [0:0] {
      SCAN   = 1'b0,
      REPORT = 1'b1
   } state_t;

   state_t               state;
   state_t               state_n;

   logic [LEN_WIDTH-1:0] acc;
   logic                 acc_ovf;     // sticky: accumulation already saturated
   logic [LEN_WIDTH-1:0] len_r;
   logic                 len_ovf_r;

   logic                 found;
   logic [LW1-1:0]       z_idx;
   logic [LW1-1:0]       add_term;
   logic [LW1-1:0]       sum;
   logic                 sum_ovf;
   logic [LEN_WIDTH-1:0] sum_sat;
   logic                 accept;
   logic                 limit_hit;

   // First NUL search, most significant byte first; later NULs are ignored.
   always_comb begin
      found = 1'b0;
      z_idx = '0;
      for (int i = 0; i < BYTES_PER_WORD; i++) begin
         if (!found && (in_data[DW-1-8*i -: 8] == 8'h00)) begin
            found = 1'b1;
            z_idx = LW1'(i);
         end
      end
   end

   // One extra bit of headroom detects overflow before saturating.
   assign add_term = found ? z_idx : LW1'(BYTES_PER_WORD);
   assign sum      = {1'b0, acc} + add_term;
   assign sum_ovf  = sum[LEN_WIDTH];
   assign sum_sat  = sum_ovf ? {LEN_WIDTH{1'b1}} : sum[LEN_WIDTH-1:0];

   assign accept   = in_valid && (state == SCAN);

`ifdef STRLEN_WORD_LIMIT_EN
   localparam int CW = (MAX_WORDS < 2) ? 1 : $clog2(MAX_WORDS + 1);

   logic [CW-1:0] word_cnt;
   logic          len_timeout_r;

   // The word being accepted now is the MAX_WORDS-th unterminated one.
   assign limit_hit   = !found && (word_cnt == CW'(MAX_WORDS - 1));
   assign len_timeout = len_timeout_r;

   always_ff @(posedge clk) begin
      if (rst) begin
         word_cnt      <= '0;
         len_timeout_r <= 1'b0;
      end else begin
         case (state)
            SCAN: begin
               if (accept) begin
                  if (found || limit_hit) begin
                     word_cnt      <= '0;
                     len_timeout_r <= limit_hit;
                  end else begin
                     word_cnt <= word_cnt + CW'(1);
                  end
               end
            end
            REPORT: begin
               if (len_ready) begin
                  len_timeout_r <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end
`else
   assign limit_hit   = 1'b0;
   assign len_timeout = 1'b0;
`endif

   // Next state and handshake outputs; in_ready never looks at in_valid.
   always_comb begin
      state_n   = state;
      in_ready  = 1'b0;
      len_valid = 1'b0;
      case (state)
         SCAN: begin
            in_ready = 1'b1;
            if (accept && (found || limit_hit)) begin
               state_n = REPORT;
            end
         end
         REPORT: begin
            len_valid = 1'b1;
            if (len_ready) begin
               state_n = SCAN;
            end
         end
         default: state_n = SCAN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= SCAN;
         acc       <= '0;
         acc_ovf   <= 1'b0;
         len_r     <= '0;
         len_ovf_r <= 1'b0;
      end else begin
         state <= state_n;
         case (state)
            SCAN: begin
               if (accept) begin
                  if (found || limit_hit) begin
                     // Terminating word: latch the result and restart the sum.
                     len_r     <= sum_sat;
                     len_ovf_r <= acc_ovf | sum_ovf;
                     acc       <= '0;
                     acc_ovf   <= 1'b0;
                  end else begin
                     acc     <= sum_sat;
                     acc_ovf <= acc_ovf | sum_ovf;
                  end
               end
            end
            REPORT: begin
               if (len_ready) begin
                  len_ovf_r <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   assign len     = len_r;
   assign len_ovf = len_ovf_r;

endmodule

// File: tb/tb_stream_strlen.sv
// tb/tb_stream_strlen.sv - self-checking bench for stream_strlen

module tb_stream_strlen;

   logic        clk = 1'b0;
   logic        rst;
   logic [63:0] in_data;
   logic        in_valid;
   logic        len_ready;
   logic [1:0]  cur;

   int checks = 0;
   int errors = 0;

   // Three instances: default, narrow length, small word limit.
   logic        d0_in_ready, d0_len_valid, d0_len_ovf, d0_len_timeout;
   logic [15:0] d0_len;
   logic        d1_in_ready, d1_len_valid, d1_len_ovf, d1_len_timeout;
   logic [3:0]  d1_len;
   logic        d2_in_ready, d2_len_valid, d2_len_ovf, d2_len_timeout;
   logic [15:0] d2_len;

   logic        m_in_ready, m_len_valid, m_len_ovf, m_len_timeout;
   logic [15:0] m_len;

   always #5 clk = ~clk;

   stream_strlen u_d0 (
      .clk(clk), .rst(rst), .in_data(in_data),
      .in_valid(in_valid && cur == 2'd0), .in_ready(d0_in_ready),
      .len(d0_len), .len_valid(d0_len_valid),
      .len_ready(len_ready && cur == 2'd0),
      .len_ovf(d0_len_ovf), .len_timeout(d0_len_timeout)
   );

   stream_strlen #(.LEN_WIDTH(4)) u_d1 (
      .clk(clk), .rst(rst), .in_data(in_data),
      .in_valid(in_valid && cur == 2'd1), .in_ready(d1_in_ready),
      .len(d1_len), .len_valid(d1_len_valid),
      .len_ready(len_ready && cur == 2'd1),
      .len_ovf(d1_len_ovf), .len_timeout(d1_len_timeout)
   );

   stream_strlen #(.MAX_WORDS(3)) u_d2 (
      .clk(clk), .rst(rst), .in_data(in_data),
      .in_valid(in_valid && cur == 2'd2), .in_ready(d2_in_ready),
      .len(d2_len), .len_valid(d2_len_valid),
      .len_ready(len_ready && cur == 2'd2),
      .len_ovf(d2_len_ovf), .len_timeout(d2_len_timeout)
   );

   always_comb begin
      m_in_ready    = d0_in_ready;
      m_len_valid   = d0_len_valid;
      m_len_ovf     = d0_len_ovf;
      m_len_timeout = d0_len_timeout;
      m_len         = d0_len;
      if (cur == 2'd1) begin
         m_in_ready    = d1_in_ready;
         m_len_valid   = d1_len_valid;
         m_len_ovf     = d1_len_ovf;
         m_len_timeout = d1_len_timeout;
         m_len         = {12'h000, d1_len};
      end else if (cur == 2'd2) begin
         m_in_ready    = d2_in_ready;
         m_len_valid   = d2_len_valid;
         m_len_ovf     = d2_len_ovf;
         m_len_timeout = d2_len_timeout;
         m_len         = d2_len;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Offer a word at a negedge and wait (bounded) for it to be taken.
   task automatic send_word(input logic [63:0] w);
      int n;
      @(negedge clk);
      in_data  = w;
      in_valid = 1'b1;
      n = 0;
      while (!m_in_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (n >= 20) check("accept_timeout", 32'(m_in_ready), 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_data  = 64'h0;
   endtask

   // Called right after the terminating word's accept edge.
   task automatic expect_result(input string name, input int exp_len,
                                input bit exp_ovf, input bit exp_to);
      @(negedge clk);
      check({name, "_len_valid"}, 32'(m_len_valid), 32'd1);
      check({name, "_in_ready_lo"}, 32'(m_in_ready), 32'd0);
      check({name, "_len"}, 32'(m_len), 32'(exp_len));
      check({name, "_ovf"}, 32'(m_len_ovf), 32'(exp_ovf));
      check({name, "_timeout"}, 32'(m_len_timeout), 32'(exp_to));
      len_ready = 1'b1;
      @(posedge clk);
      #1;
      len_ready = 1'b0;
      @(negedge clk);
      check({name, "_valid_drop"}, 32'(m_len_valid), 32'd0);
      check({name, "_ready_back"}, 32'(m_in_ready), 32'd1);
      check({name, "_ovf_clear"}, 32'(m_len_ovf), 32'd0);
      check({name, "_to_clear"}, 32'(m_len_timeout), 32'd0);
   endtask

   typedef struct {
      logic [1:0]  sel;
      int          n;
      logic [63:0] w0;
      logic [63:0] w1;
      logic [63:0] w2;
      int          exp_len;
      bit          exp_ovf;
   } vec_t;

   vec_t tbl[10];

   initial begin
      tbl[0] = '{2'd0, 1, 64'hAABBCCDDEEFFAA00, 64'h0, 64'h0, 7, 1'b0};
      tbl[1] = '{2'd0, 1, 64'hAABBCCDDEEFF00AA, 64'h0, 64'h0, 6, 1'b0};
      tbl[2] = '{2'd0, 2, 64'hAABBCCDDEEFFAA99, 64'h1122000000000000, 64'h0, 10, 1'b0};
      tbl[3] = '{2'd0, 1, 64'h00BBCCDDEE44FFAA, 64'h0, 64'h0, 0, 1'b0};
      tbl[4] = '{2'd0, 1, 64'hAABBCC00EE00FFAA, 64'h0, 64'h0, 3, 1'b0};
      tbl[5] = '{2'd0, 3, 64'h0102030405060708, 64'h1112131415161718, 64'h2122232425262700, 23, 1'b0};
      tbl[6] = '{2'd1, 3, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 64'h00FFFFFFFFFFFFFF, 15, 1'b1};
      tbl[7] = '{2'd1, 1, 64'hAA00000000000000, 64'h0, 64'h0, 1, 1'b0};
      tbl[8] = '{2'd1, 2, 64'hFFFFFFFFFFFFFFFF, 64'hAABBCCDDEEFFAA00, 64'h0, 15, 1'b0};
      tbl[9] = '{2'd2, 2, 64'h0102030405060708, 64'h0900000000000000, 64'h0, 9, 1'b0};

      rst       = 1'b1;
      in_data   = 64'h0;
      in_valid  = 1'b0;
      len_ready = 1'b0;
      cur       = 2'd0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_len", 32'(d0_len), 32'd0);
      check("rst_len_valid", 32'(d0_len_valid), 32'd0);
      check("rst_in_ready", 32'(d0_in_ready), 32'd1);
      check("rst_ovf", 32'(d0_len_ovf), 32'd0);
      check("rst_timeout", 32'(d0_len_timeout), 32'd0);
      check("rst_d1_len_valid", 32'(d1_len_valid), 32'd0);
      rst = 1'b0;

      for (int i = 0; i < 10; i++) begin
         cur = tbl[i].sel;
         send_word(tbl[i].w0);
         if (tbl[i].n > 1) send_word(tbl[i].w1);
         if (tbl[i].n > 2) send_word(tbl[i].w2);
         expect_result($sformatf("vec%0d", i), tbl[i].exp_len, tbl[i].exp_ovf, 1'b0);
      end

      // Back-pressure: result held for 5 cycles while a new word waits.
      cur = 2'd0;
      send_word(64'h44BBC00DEE44FFAA);
      send_word(64'h0000000000000000);
      in_data  = 64'hAA00000000000000;
      in_valid = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check($sformatf("hold%0d_valid", k), 32'(m_len_valid), 32'd1);
         check($sformatf("hold%0d_len", k), 32'(m_len), 32'd8);
         check($sformatf("hold%0d_in_ready", k), 32'(m_in_ready), 32'd0);
      end
      len_ready = 1'b1;
      @(posedge clk);
      #1;
      len_ready = 1'b0;
      @(negedge clk);
      check("hold_after_valid", 32'(m_len_valid), 32'd0);
      check("hold_after_in_ready", 32'(m_in_ready), 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      expect_result("hold_next", 1, 1'b0, 1'b0);

      // Reset mid-string discards the partial length.
      send_word(64'h1111111111111111);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("rst_mid_valid", 32'(m_len_valid), 32'd0);
      check("rst_mid_in_ready", 32'(m_in_ready), 32'd1);
      send_word(64'h1100000000000000);
      expect_result("rst_mid", 1, 1'b0, 1'b0);

      // Reset during REPORT drops the pending result.
      send_word(64'hAABBCCDDEEFFAA00);
      @(negedge clk);
      check("rst_rep_pre_valid", 32'(m_len_valid), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("rst_rep_valid", 32'(m_len_valid), 32'd0);
      check("rst_rep_len", 32'(m_len), 32'd0);
      check("rst_rep_in_ready", 32'(m_in_ready), 32'd1);

      // Word limit of 3 on the third instance.
      cur = 2'd2;
      send_word(64'h0102030405060708);
      send_word(64'h1112131415161718);
      send_word(64'h2122232425262728);
`ifdef STRLEN_WORD_LIMIT_EN
      expect_result("limit", 24, 1'b0, 1'b1);
`else
      repeat (3) @(negedge clk);
      check("nolimit_valid", 32'(m_len_valid), 32'd0);
      check("nolimit_in_ready", 32'(m_in_ready), 32'd1);
      send_word(64'h0000000000000000);
      expect_result("nolimit", 24, 1'b0, 1'b0);
`endif
      send_word(64'hAA00000000000000);
      expect_result("limit_next", 1, 1'b0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
      $fatal(1);
   end

endmodule
